memory_access_stage: RTL and testbench

MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

---
 rtl/memory_access_stage.sv | 192 +++++++++++++++++++
 tb/tb_memory_access_stage.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_stage.sv
// memory_access_stage
//
// Resolves up to three memory operands for one instruction. The stage
// takes a request, then walks through source-1 read, source-2 read and
// destination write in that fixed order, issuing only the accesses whose
// flag is set. Unflagged source operands pass straight through. When all
// accesses are done the result is held in DONE until downstream is ready.
//
// Ports
//   clk, reset                 single clock, synchronous active-high reset
//   addrValidIn / readyOut     request handshake (accept = both high)
//   isMemoryAccess*In          per-operand memory flags
//   memoryAddress*In           64-bit operand addresses (used as-is)
//   operand1ValIn/2ValIn       register operand values
//   storeDataIn                data written to the destination address
//   memReqOut, memWriteOut,
//   memAddrOut, memWriteDataOut  memory request port
//   memAckIn, memReadDataIn    memory response port
//   operand1ValOut/2ValOut     resolved operands
//   resultValidOut, stallIn    result handshake with downstream
//   faultOut                   sticky memory timeout fault
//
// Optional feature: define MEM_ACCESS_TIMEOUT_EN to abort an access that
// goes 255 cycles without an acknowledge. Without it, accesses wait
// indefinitely and faultOut is tied low.

module memory_access_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        addrValidIn,
    output logic        readyOut,
    input  logic        isMemoryAccessSrc1In,
    input  logic        isMemoryAccessSrc2In,
    input  logic        isMemoryAccessDestIn,
    input  logic [63:0] memoryAddressSrc1In,
    input  logic [63:0] memoryAddressSrc2In,
    input  logic [63:0] memoryAddressDestIn,
    input  logic [63:0] operand1ValIn,
    input  logic [63:0] operand2ValIn,
    input  logic [63:0] storeDataIn,
    output logic        memReqOut,
    output logic        memWriteOut,
    output logic [63:0] memAddrOut,
    output logic [63:0] memWriteDataOut,
    input  logic        memAckIn,
    input  logic [63:0] memReadDataIn,
    output logic [63:0] operand1ValOut,
    output logic [63:0] operand2ValOut,
    output logic        resultValidOut,
    input  logic        stallIn,
    output logic        faultOut
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] READ_SRC1  = 3'd1;
    localparam logic [2:0] READ_SRC2  = 3'd2;
    localparam logic [2:0] WRITE_DEST = 3'd3;
    localparam logic [2:0] DONE       = 3'd4;

    logic [2:0]  state;
    logic [2:0]  first_state;
    logic [2:0]  after_access;
    logic        src2_q;
    logic        dest_q;
    logic [63:0] addr_src1_q;
    logic [63:0] addr_src2_q;
    logic [63:0] addr_dest_q;
    logic [63:0] store_data_q;
    logic        timeout;

    // First access to perform, decided from the live flags at acceptance.
    always_comb begin
        first_state = DONE;
        if (isMemoryAccessSrc1In)      first_state = READ_SRC1;
        else if (isMemoryAccessSrc2In) first_state = READ_SRC2;
        else if (isMemoryAccessDestIn) first_state = WRITE_DEST;
    end

    // Next access after the current one completes, from the captured flags.
    always_comb begin
        after_access = DONE;
        case (state)
            READ_SRC1: begin
                if (src2_q)      after_access = READ_SRC2;
                else if (dest_q) after_access = WRITE_DEST;
            end
            READ_SRC2: begin
                if (dest_q) after_access = WRITE_DEST;
            end
            default: after_access = DONE;
        endcase
    end

    // Memory port is a pure decode of the state, so it drops to zero the
    // cycle any access ends (ack, timeout or reset).
    always_comb begin
        readyOut        = (state == IDLE);
        resultValidOut  = (state == DONE);
        memReqOut       = 1'b0;
        memWriteOut     = 1'b0;
        memAddrOut      = '0;
        memWriteDataOut = '0;
        case (state)
            READ_SRC1: begin
                memReqOut  = 1'b1;
                memAddrOut = addr_src1_q;
            end
            READ_SRC2: begin
                memReqOut  = 1'b1;
                memAddrOut = addr_src2_q;
            end
            WRITE_DEST: begin
                memReqOut       = 1'b1;
                memWriteOut     = 1'b1;
                memAddrOut      = addr_dest_q;
                memWriteDataOut = store_data_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            src2_q         <= 1'b0;
            dest_q         <= 1'b0;
            addr_src1_q    <= '0;
            addr_src2_q    <= '0;
            addr_dest_q    <= '0;
            store_data_q   <= '0;
            operand1ValOut <= '0;
            operand2ValOut <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (addrValidIn) begin
                        src2_q         <= isMemoryAccessSrc2In;
                        dest_q         <= isMemoryAccessDestIn;
                        addr_src1_q    <= memoryAddressSrc1In;
                        addr_src2_q    <= memoryAddressSrc2In;
                        addr_dest_q    <= memoryAddressDestIn;
                        store_data_q   <= storeDataIn;
                        operand1ValOut <= operand1ValIn;
                        operand2ValOut <= operand2ValIn;
                        state          <= first_state;
                    end
                end
                READ_SRC1, READ_SRC2, WRITE_DEST: begin
                    // Acks only count here, where memReqOut is high.
                    if (memAckIn) begin
                        if (state == READ_SRC1) operand1ValOut <= memReadDataIn;
                        if (state == READ_SRC2) operand2ValOut <= memReadDataIn;
                        state <= after_access;
                    end else if (timeout) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!stallIn) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       fault_q;

    // Counter is zero whenever no access is waiting, so every access state
    // starts counting from zero. It reaches 255 on the same edge the
    // access is abandoned.
    always_ff @(posedge clk) begin
        if (reset)                      wait_cnt <= '0;
        else if (!memReqOut || memAckIn) wait_cnt <= '0;
        else                            wait_cnt <= wait_cnt + 8'd1;
    end

    assign timeout = memReqOut && !memAckIn && (wait_cnt == 8'd254);

    always_ff @(posedge clk) begin
        if (reset)        fault_q <= 1'b0;
        else if (timeout) fault_q <= 1'b1;
    end

    assign faultOut = fault_q;
`else
    assign timeout  = 1'b0;
    assign faultOut = 1'b0;
`endif

endmodule

// File: tb/tb_memory_access_stage.sv
// Testbench for memory_access_stage: directed table of transactions,
// randomized transactions checked against an access-list model, and
// hand-written sequences for reset, handshake and timeout corner cases.

module tb_memory_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        addrValidIn;
    logic        readyOut;
    logic        isMemoryAccessSrc1In, isMemoryAccessSrc2In, isMemoryAccessDestIn;
    logic [63:0] memoryAddressSrc1In, memoryAddressSrc2In, memoryAddressDestIn;
    logic [63:0] operand1ValIn, operand2ValIn, storeDataIn;
    logic        memReqOut, memWriteOut;
    logic [63:0] memAddrOut, memWriteDataOut;
    logic        memAckIn;
    logic [63:0] memReadDataIn;
    logic [63:0] operand1ValOut, operand2ValOut;
    logic        resultValidOut;
    logic        stallIn;
    logic        faultOut;

    always #5 clk = ~clk;

    memory_access_stage dut (
        .clk                  (clk),
        .reset                (reset),
        .addrValidIn          (addrValidIn),
        .readyOut             (readyOut),
        .isMemoryAccessSrc1In (isMemoryAccessSrc1In),
        .isMemoryAccessSrc2In (isMemoryAccessSrc2In),
        .isMemoryAccessDestIn (isMemoryAccessDestIn),
        .memoryAddressSrc1In  (memoryAddressSrc1In),
        .memoryAddressSrc2In  (memoryAddressSrc2In),
        .memoryAddressDestIn  (memoryAddressDestIn),
        .operand1ValIn        (operand1ValIn),
        .operand2ValIn        (operand2ValIn),
        .storeDataIn          (storeDataIn),
        .memReqOut            (memReqOut),
        .memWriteOut          (memWriteOut),
        .memAddrOut           (memAddrOut),
        .memWriteDataOut      (memWriteDataOut),
        .memAckIn             (memAckIn),
        .memReadDataIn        (memReadDataIn),
        .operand1ValOut       (operand1ValOut),
        .operand2ValOut       (operand2ValOut),
        .resultValidOut       (resultValidOut),
        .stallIn              (stallIn),
        .faultOut             (faultOut)
    );

    typedef struct {
        logic        f1, f2, fd;
        logic [63:0] a1, a2, ad, v1, v2, sd, r1, r2;
        int unsigned d1, d2, dd, stall;
        logic [63:0] exp1, exp2;
        int unsigned exp_lat;
    } vec_t;

    typedef struct {
        logic        wr;
        logic [63:0] addr;
        logic [63:0] data;
        int unsigned dly;
    } acc_t;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic vec_t vz();
        vec_t v;
        v.f1 = 1'b0; v.f2 = 1'b0; v.fd = 1'b0;
        v.a1 = '0; v.a2 = '0; v.ad = '0; v.v1 = '0; v.v2 = '0;
        v.sd = '0; v.r1 = '0; v.r2 = '0;
        v.d1 = 0; v.d2 = 0; v.dd = 0; v.stall = 0;
        v.exp1 = '0; v.exp2 = '0; v.exp_lat = 0;
        return v;
    endfunction

    // Reference: a flagged source takes its read data, otherwise the
    // register value; each access costs its ack wait plus one cycle.
    function automatic vec_t model(input vec_t v);
        v.exp1    = v.f1 ? v.r1 : v.v1;
        v.exp2    = v.f2 ? v.r2 : v.v2;
        v.exp_lat = 1 + (v.f1 ? v.d1 + 1 : 0) + (v.f2 ? v.d2 + 1 : 0) + (v.fd ? v.dd + 1 : 0);
        return v;
    endfunction

    task automatic scramble_inputs();
        isMemoryAccessSrc1In = 1'($urandom_range(0, 1));
        isMemoryAccessSrc2In = 1'($urandom_range(0, 1));
        isMemoryAccessDestIn = 1'($urandom_range(0, 1));
        memoryAddressSrc1In  = rnd64();
        memoryAddressSrc2In  = rnd64();
        memoryAddressDestIn  = rnd64();
        operand1ValIn        = rnd64();
        operand2ValIn        = rnd64();
        storeDataIn          = rnd64();
    endtask

    task automatic check_reset_vals(input string tag);
        chk64({tag, "_ready"},  {63'b0, readyOut},       64'd1);
        chk64({tag, "_req"},    {63'b0, memReqOut},      64'd0);
        chk64({tag, "_wr"},     {63'b0, memWriteOut},    64'd0);
        chk64({tag, "_addr"},   memAddrOut,              64'd0);
        chk64({tag, "_wdata"},  memWriteDataOut,         64'd0);
        chk64({tag, "_op1"},    operand1ValOut,          64'd0);
        chk64({tag, "_op2"},    operand2ValOut,          64'd0);
        chk64({tag, "_valid"},  {63'b0, resultValidOut}, 64'd0);
        chk64({tag, "_fault"},  {63'b0, faultOut},       64'd0);
    endtask

    task automatic run_txn(input vec_t v);
        acc_t        q[$];
        acc_t        a;
        int unsigned cyc, waited, guard;
        if (v.f1) begin a.wr = 1'b0; a.addr = v.a1; a.data = v.r1; a.dly = v.d1; q.push_back(a); end
        if (v.f2) begin a.wr = 1'b0; a.addr = v.a2; a.data = v.r2; a.dly = v.d2; q.push_back(a); end
        if (v.fd) begin a.wr = 1'b1; a.addr = v.ad; a.data = v.sd; a.dly = v.dd; q.push_back(a); end

        isMemoryAccessSrc1In = v.f1;
        isMemoryAccessSrc2In = v.f2;
        isMemoryAccessDestIn = v.fd;
        memoryAddressSrc1In  = v.a1;
        memoryAddressSrc2In  = v.a2;
        memoryAddressDestIn  = v.ad;
        operand1ValIn        = v.v1;
        operand2ValIn        = v.v2;
        storeDataIn          = v.sd;
        memAckIn             = 1'b1;   // stray ack while idle must be ignored
        stallIn              = 1'b0;
        addrValidIn          = 1'b1;
        guard = 0;
        while (!readyOut && guard < 20) begin
            tick();
            guard++;
        end
        chk64("ready_before_accept", {63'b0, readyOut}, 64'd1);
        tick();
        addrValidIn = 1'b0;
        scramble_inputs();

        cyc    = 1;
        waited = 0;
        while (!resultValidOut && cyc < 2000) begin
            memAckIn      = 1'b0;
            memReadDataIn = rnd64();
            chk64("req_active", {63'b0, memReqOut}, {63'b0, q.size() != 0});
            if (memReqOut && q.size() != 0) begin
                a = q[0];
                chk64("req_write", {63'b0, memWriteOut}, {63'b0, a.wr});
                chk64("req_addr", memAddrOut, a.addr);
                if (a.wr) chk64("req_wdata", memWriteDataOut, a.data);
                if (waited == a.dly) begin
                    memAckIn = 1'b1;
                    if (!a.wr) memReadDataIn = a.data;
                    void'(q.pop_front());
                    waited = 0;
                end else begin
                    waited++;
                end
            end else if (!memReqOut) begin
                memAckIn = 1'($urandom_range(0, 1));
            end
            tick();
            cyc++;
        end
        memAckIn = 1'b0;
        chk64("result_valid", {63'b0, resultValidOut}, 64'd1);
        chk64("latency", 64'(cyc), 64'(v.exp_lat));
        chk64("accesses_left", 64'(q.size()), 64'd0);
        chk64("op1", operand1ValOut, v.exp1);
        chk64("op2", operand2ValOut, v.exp2);
        chk64("done_req", {63'b0, memReqOut}, 64'd0);
        chk64("done_ready", {63'b0, readyOut}, 64'd0);
        chk64("fault", {63'b0, faultOut}, 64'd0);

        // Hold in DONE; a new request offered meanwhile must not be taken.
        for (int unsigned i = 0; i < v.stall; i++) begin
            stallIn     = 1'b1;
            addrValidIn = 1'b1;
            tick();
            chk64("stall_valid", {63'b0, resultValidOut}, 64'd1);
            chk64("stall_op1", operand1ValOut, v.exp1);
            chk64("stall_op2", operand2ValOut, v.exp2);
        end
        stallIn     = 1'b0;
        addrValidIn = 1'b0;
        tick();
        chk64("release_ready", {63'b0, readyOut}, 64'd1);
        chk64("release_valid", {63'b0, resultValidOut}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[$];
        vec_t        v;
        int unsigned n;

        // No flags: operands pass straight through.
        v = vz(); v.v1 = 64'h11; v.v2 = 64'h22;
        v.exp1 = 64'h11; v.exp2 = 64'h22; v.exp_lat = 1;
        tbl.push_back(v);
        // Source-1 read acked after three wait cycles.
        v = vz(); v.f1 = 1'b1; v.a1 = 64'h1000; v.d1 = 3; v.r1 = 64'hDEADBEEF;
        v.v1 = 64'h99; v.v2 = 64'h1234;
        v.exp1 = 64'hDEADBEEF; v.exp2 = 64'h1234; v.exp_lat = 5;
        tbl.push_back(v);
        // All three accesses, immediate acks.
        v = vz(); v.f1 = 1'b1; v.f2 = 1'b1; v.fd = 1'b1;
        v.a1 = 64'h100; v.a2 = 64'h200; v.ad = 64'h300; v.sd = 64'h55;
        v.r1 = 64'hA1A1; v.r2 = 64'hB2B2; v.v1 = 64'h1; v.v2 = 64'h2;
        v.exp1 = 64'hA1A1; v.exp2 = 64'hB2B2; v.exp_lat = 4;
        tbl.push_back(v);
        // Downstream stall held for five cycles.
        v = vz(); v.v1 = 64'h33; v.v2 = 64'h44; v.stall = 5;
        v.exp1 = 64'h33; v.exp2 = 64'h44; v.exp_lat = 1;
        tbl.push_back(v);
        // Destination write only; sources pass through.
        v = vz(); v.fd = 1'b1; v.ad = 64'hFFFF_FFFF_FFFF_FFFF; v.sd = 64'hFFFF_FFFF_FFFF_FFFF;
        v.dd = 2; v.v1 = 64'h7; v.v2 = 64'h8;
        v.exp1 = 64'h7; v.exp2 = 64'h8; v.exp_lat = 4;
        tbl.push_back(v);
        // Source-2 read at the top of the address space.
        v = vz(); v.f2 = 1'b1; v.a2 = 64'hFFFF_FFFF_FFFF_FFF8; v.d2 = 1; v.r2 = 64'h0;
        v.v1 = 64'hCAFE; v.v2 = 64'hFFFF_FFFF_FFFF_FFFF;
        v.exp1 = 64'hCAFE; v.exp2 = 64'h0; v.exp_lat = 3;
        tbl.push_back(v);

        reset       = 1'b1;
        addrValidIn = 1'b0;
        stallIn     = 1'b0;
        memAckIn    = 1'b0;
        memReadDataIn = '0;
        scramble_inputs();
        tick();
        tick();
        check_reset_vals("reset");
        reset = 1'b0;
        tick();
        chk64("post_reset_ready", {63'b0, readyOut}, 64'd1);

        for (int unsigned i = 0; i < tbl.size(); i++) run_txn(tbl[i]);

        for (int unsigned i = 0; i < 40; i++) begin
            v = vz();
            v.f1 = 1'($urandom_range(0, 1));
            v.f2 = 1'($urandom_range(0, 1));
            v.fd = 1'($urandom_range(0, 1));
            v.a1 = rnd64(); v.a2 = rnd64(); v.ad = rnd64();
            v.v1 = rnd64(); v.v2 = rnd64(); v.sd = rnd64();
            v.r1 = rnd64(); v.r2 = rnd64();
            v.d1 = $urandom_range(0, 4); v.d2 = $urandom_range(0, 4); v.dd = $urandom_range(0, 4);
            v.stall = $urandom_range(0, 3);
            run_txn(model(v));
        end

        // A request held high across DONE is taken only after one IDLE cycle.
        isMemoryAccessSrc1In = 1'b0;
        isMemoryAccessSrc2In = 1'b0;
        isMemoryAccessDestIn = 1'b0;
        operand1ValIn = 64'hA1; operand2ValIn = 64'hA2;
        addrValidIn = 1'b1;
        stallIn     = 1'b0;
        memAckIn    = 1'b0;
        tick();
        chk64("b2b_done_valid", {63'b0, resultValidOut}, 64'd1);
        chk64("b2b_done_ready", {63'b0, readyOut}, 64'd0);
        tick();
        chk64("b2b_idle_valid", {63'b0, resultValidOut}, 64'd0);
        chk64("b2b_idle_ready", {63'b0, readyOut}, 64'd1);
        operand1ValIn = 64'hB1;
        tick();
        chk64("b2b_second_valid", {63'b0, resultValidOut}, 64'd1);
        chk64("b2b_second_op1", operand1ValOut, 64'hB1);
        addrValidIn = 1'b0;
        tick();
        chk64("b2b_end_ready", {63'b0, readyOut}, 64'd1);

        // Reset while source-2 read is outstanding, then a stray ack.
        isMemoryAccessSrc1In = 1'b1;
        isMemoryAccessSrc2In = 1'b1;
        isMemoryAccessDestIn = 1'b0;
        memoryAddressSrc1In  = 64'h10;
        memoryAddressSrc2In  = 64'hAB0;
        addrValidIn = 1'b1;
        tick();
        chk64("abort_src1_addr", memAddrOut, 64'h10);
        addrValidIn   = 1'b0;
        memAckIn      = 1'b1;
        memReadDataIn = 64'h77;
        tick();
        chk64("abort_src2_req", {63'b0, memReqOut}, 64'd1);
        chk64("abort_src2_addr", memAddrOut, 64'hAB0);
        chk64("abort_src1_data", operand1ValOut, 64'h77);
        memAckIn = 1'b0;
        reset    = 1'b1;
        tick();
        check_reset_vals("abort_reset");
        reset    = 1'b0;
        memAckIn = 1'b1;
        tick();
        check_reset_vals("abort_stray_ack");
        memAckIn = 1'b0;

`ifdef MEM_ACCESS_TIMEOUT_EN
        // Unacknowledged read gives up after 255 request cycles.
        isMemoryAccessSrc1In = 1'b1;
        isMemoryAccessSrc2In = 1'b1;
        isMemoryAccessDestIn = 1'b1;
        memoryAddressSrc1In  = 64'h2000;
        addrValidIn = 1'b1;
        tick();
        addrValidIn = 1'b0;
        n = 0;
        while (memReqOut && n < 400) begin
            tick();
            n++;
        end
        chk64("timeout_req_cycles", 64'(n), 64'd255);
        chk64("timeout_fault", {63'b0, faultOut}, 64'd1);
        chk64("timeout_valid", {63'b0, resultValidOut}, 64'd1);
        tick();
        chk64("timeout_idle_ready", {63'b0, readyOut}, 64'd1);
        tick();
        chk64("timeout_fault_sticky", {63'b0, faultOut}, 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk64("timeout_fault_cleared", {63'b0, faultOut}, 64'd0);
`else
        // Without the timeout an access waits as long as it takes.
        isMemoryAccessSrc1In = 1'b1;
        isMemoryAccessSrc2In = 1'b0;
        isMemoryAccessDestIn = 1'b0;
        memoryAddressSrc1In  = 64'h2000;
        addrValidIn = 1'b1;
        tick();
        addrValidIn = 1'b0;
        n = 0;
        while (memReqOut && n < 300) begin
            tick();
            n++;
        end
        chk64("long_wait_req", {63'b0, memReqOut}, 64'd1);
        chk64("long_wait_addr", memAddrOut, 64'h2000);
        chk64("long_wait_fault", {63'b0, faultOut}, 64'd0);
        memAckIn      = 1'b1;
        memReadDataIn = 64'h5A;
        tick();
        memAckIn = 1'b0;
        chk64("long_wait_valid", {63'b0, resultValidOut}, 64'd1);
        chk64("long_wait_op1", operand1ValOut, 64'h5A);
        tick();
        chk64("long_wait_ready", {63'b0, readyOut}, 64'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
